// File: rtl/alu_datapath.sv
// Multi-cycle ALU: single-cycle ADD/SUB, iterative shift-add MUL and optional restoring DIV.
// Define ALU_DATAPATH_DIV_EN to build the divider; otherwise opcode 3 is invalid.
module alu_datapath #(
  parameter int WIDTH = 16,
  parameter int OPW   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [3:0]       i_opcode,
  input  logic [OPW-1:0]   i_a,
  input  logic [OPW-1:0]   i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(OPW + 1);
  localparam logic [CW-1:0] ITER = CW'(OPW);

  typedef enum logic [1:0] {IDLE, CALC, DONE, HOLD} state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [2*OPW-1:0] r_acc;
  logic [OPW-1:0]   r_opnd;
  logic [WIDTH-1:0] r_result;
  logic [2*OPW-1:0] w_acc_step;
  logic [2*OPW-1:0] w_mul_step;
  logic [OPW:0]     w_mul_sum;
  logic [OPW:0]     w_add;
  logic [OPW:0]     w_sub;
  logic [WIDTH-1:0] w_short_result;
  logic             w_accept, w_is_mul, w_is_div, w_iter, w_last;

  assign w_accept = (r_state == IDLE) && i_enable;
  assign w_is_mul = (i_opcode == 4'd2);
  assign w_iter   = w_is_mul | w_is_div;
  assign w_last   = (r_cnt == CW'(1));

  // Product register holds {partial sum, remaining multiplier bits}; shifts right each step.
  assign w_mul_sum  = {1'b0, r_acc[2*OPW-1:OPW]} + {1'b0, (r_acc[0] ? r_opnd : {OPW{1'b0}})};
  assign w_mul_step = {w_mul_sum, r_acc[OPW-1:1]};

`ifdef ALU_DATAPATH_DIV_EN
  logic             r_div;
  logic             r_dbz;
  logic [OPW:0]     w_shift;
  logic [OPW+1:0]   w_diff;
  logic [2*OPW-1:0] w_div_step;

  assign w_is_div = (i_opcode == 4'd3);
  // Division register holds {remainder, dividend/quotient}; a zero divisor naturally yields all-ones/a.
  assign w_shift    = r_acc[2*OPW-1:OPW-1];
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_opnd};
  assign w_div_step = w_diff[OPW+1] ? {w_shift[OPW-1:0], r_acc[OPW-2:0], 1'b0}
                                    : {w_diff[OPW-1:0],  r_acc[OPW-2:0], 1'b1};
  assign w_acc_step    = r_div ? w_div_step : w_mul_step;
  assign o_div_by_zero = r_dbz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= 1'b0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_div <= w_is_div;
      r_dbz <= 1'b0;
    end else if (r_state == CALC && w_last) begin
      r_dbz <= r_div && (r_opnd == '0);
    end
  end
`else
  assign w_is_div      = 1'b0;
  assign w_acc_step    = w_mul_step;
  assign o_div_by_zero = 1'b0;
`endif

  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    w_short_result = '0;
    case (i_opcode)
      4'd0:    w_short_result = WIDTH'(w_add);
      4'd1:    w_short_result = {{(WIDTH-OPW-1){w_sub[OPW]}}, w_sub};
      default: w_short_result = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_enable) w_state_next = w_iter ? CALC : DONE;
      CALC:    if (w_last) w_state_next = DONE;
      DONE:    w_state_next = i_enable ? HOLD : IDLE;
      HOLD:    if (!i_enable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt  <= ITER;
        r_opnd <= w_is_mul ? i_a : i_b;
        r_acc  <= {{OPW{1'b0}}, (w_is_mul ? i_b : i_a)};
        if (!w_iter) r_result <= w_short_result;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt - CW'(1);
        r_acc <= w_acc_step;
        if (w_last) r_result <= WIDTH'(w_acc_step);
      end
    end
  end

  assign o_result = r_result;
  assign o_done   = (r_state == DONE);
  assign o_busy   = (r_state == CALC) || (r_state == DONE);

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath with a result scoreboard and immediate-assertion checks.
module tb_alu_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  opcode = '0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] result;
  logic        done, busy, div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        dbz;
    int          lat;
    string       tag;
  } exp_t;
  exp_t sb[$];

  alu_datapath #(.WIDTH(16), .OPW(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_opcode(opcode),
    .i_a(a), .i_b(b), .o_result(result), .o_done(done), .o_busy(busy),
    .o_div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble operands after acceptance, and compare against the scoreboard.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input logic [15:0] eres, input logic edbz,
                        input int elat, input int drop_at);
    exp_t e;
    int   n;
    bit   got;
    bit   busy_ok;
    @(negedge clk);
    opcode = op; a = va; b = vb; enable = 1'b1;
    sb.push_back('{eres, edbz, elat, tag});
    n = 0; got = 0; busy_ok = 1;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      a = 8'($urandom); b = 8'($urandom); opcode = 4'($urandom_range(0, 3));
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) got = 1;
      if (n == drop_at) enable = 1'b0;
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    check({e.tag, " latency"}, 32'(n), 32'(e.lat));
    check({e.tag, " busy_during"}, 32'(busy_ok), 32'd1);
    check({e.tag, " result"}, 32'(result), 32'(e.res));
    check({e.tag, " div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
    $display("op %-10s opcode=%0d a=%0d b=%0d -> result=0x%04h dbz=%0b latency=%0d",
             e.tag, op, va, vb, result, div_by_zero, n);
    enable = 1'b0;
    @(negedge clk);
    check({e.tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({e.tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int extra;
    // Reset state
    #2;
    check("reset result", 32'(result), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("ADD255", 4'd0, 8'd255, 8'd255, 16'h01FE, 1'b0, 1, 0);

    // Abort MUL mid-calculation with asynchronous reset
    @(negedge clk);
    opcode = 4'd2; a = 8'd200; b = 8'd3; enable = 1'b1;
    repeat (4) @(negedge clk);
    check("mul_abort busy_calc", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mul_abort result", 32'(result), 32'd0);
    check("mul_abort done", 32'(done), 32'd0);
    check("mul_abort busy", 32'(busy), 32'd0);
    check("mul_abort dbz", 32'(div_by_zero), 32'd0);
    enable = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("mul_abort no_done", 32'(extra), 32'd0);
    rst_n = 1'b1;
    $display("op reset-abort  MUL 200x3 aborted, outputs cleared");

    run_op("ADD1", 4'd0, 8'd1, 8'd1, 16'h0002, 1'b0, 1, 0);
    run_op("SUB3-5", 4'd1, 8'd3, 8'd5, 16'hFFFE, 1'b0, 1, 0);
    run_op("SUB200-7", 4'd1, 8'd200, 8'd7, 16'h00C1, 1'b0, 1, 0);
    run_op("MUL255", 4'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 9, 0);
    run_op("MUL13x11", 4'd2, 8'd13, 8'd11, 16'h008F, 1'b0, 9, 3);
    run_op("MULx0", 4'd2, 8'd77, 8'd0, 16'h0000, 1'b0, 9, 0);
    run_op("INV7", 4'd7, 8'd9, 8'd3, 16'h0000, 1'b0, 1, 0);
`ifdef ALU_DATAPATH_DIV_EN
    run_op("DIV200/7", 4'd3, 8'd200, 8'd7, 16'h041C, 1'b0, 9, 0);
    run_op("DIV9/0", 4'd3, 8'd9, 8'd0, 16'h09FF, 1'b1, 9, 0);
    run_op("DIV255/255", 4'd3, 8'd255, 8'd255, 16'h0001, 1'b0, 9, 0);
`else
    run_op("OP3inval", 4'd3, 8'd9, 8'd3, 16'h0000, 1'b0, 1, 0);
`endif

    // Enable held high after done: exactly one pulse, then re-issue after one low cycle
    @(negedge clk);
    opcode = 4'd0; a = 8'd10; b = 8'd20; enable = 1'b1;
    @(negedge clk);
    check("hold first_done", 32'(done), 32'd1);
    check("hold result", 32'(result), 32'd30);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("hold extra_done", 32'(extra), 32'd0);
    check("hold result_kept", 32'(result), 32'd30);
    $display("op hold        enable high 5 cycles, extra done pulses=%0d", extra);
    enable = 1'b0;
    run_op("ADD2+3", 4'd0, 8'd2, 8'd3, 16'h0005, 1'b0, 1, 0);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
# alu_datapath

Multi-cycle arithmetic datapath that sits directly downstream of the instruction controller. It accepts one decoded operation (opcode, a, b) per `enable` assertion and executes it. Single-cycle ops are ADD and SUB; iterative ops are MUL and, optionally, DIV. It returns a result with a one-cycle `done` pulse, which the controller uses to advance the program counter.

## Interface
- `WIDTH`, default 16: result width; must be ≥ 2·`OPW`.
- `OPW`, default 8: operand width; also the iteration count for MUL/DIV.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `enable` input 1: operation request, level; held high by the controller until it sees `done`.
- `opcode` input 4: 0 ADD, 1 SUB, 2 MUL, 3 DIV; 4–15 invalid.
- `a` input `OPW`: operand A, sampled only at acceptance.
- `b` input `OPW`: operand B, sampled only at acceptance.
- `result` output `WIDTH`: registered result; holds until the next acceptance.
- `done` output 1: one-cycle completion pulse.
- `busy` output 1: high from the cycle after acceptance through the `done` cycle.
- `div_by_zero` output 1: registered flag, valid from the `done` cycle until the next acceptance.

## Operation
- States:
  - IDLE
  - CALC
  - DONE
  - HOLD
- Acceptance: in IDLE with `enable`=1 at a rising edge.
  - Latch opcode, a, b.
  - Clear `div_by_zero`.
  - Load the iteration counter with `OPW`.
- IDLE → DONE: on acceptance of ADD, SUB or an invalid opcode.
- IDLE → CALC: on acceptance of MUL or DIV.
- CALC: one shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle; counter decrements; → DONE when the counter reaches 1 at the edge.
- DONE: `done`=1 and `result` valid.
  - → IDLE if `enable`=0.
  - → HOLD if `enable`=1.
- HOLD: wait for `enable`=0, then → IDLE. A still-high `enable` never starts a second operation.
- Arithmetic (operands unsigned):
  - ADD: `result` = zero-extended a+b (max 510, no overflow).
  - SUB: `result` = a−b sign-extended to `WIDTH` (two's complement).
  - MUL: `result` = full 2·`OPW`-bit product, zero-extended.
  - DIV: `result` = {remainder, quotient}, remainder in bits [2·OPW−1:OPW] and quotient in bits [OPW−1:0].
  - DIV with b=0: quotient all ones, remainder = a, `div_by_zero`=1.
  - Invalid opcode: `result`=0.
- `result` is updated only on entry to DONE. Intermediate accumulators are internal and never visible on `result`.

## Timing
- Reset values: state IDLE, `result`=0, `done`=0, `busy`=0, `div_by_zero`=0, counter 0. All apply asynchronously on `reset`=0.
- Let acceptance happen at edge E.
  - ADD/SUB/invalid: `done` is high in the cycle after E (latency 1).
  - MUL/DIV: `done` is high `OPW`+1 cycles after E (latency 9 at the default).
- `done` lasts exactly one cycle. `busy` falls the cycle after `done`.
- Back-to-back issue: the earliest next acceptance is the edge after `enable` is first sampled low following DONE. With the controller's fetch/decode states this gives a minimum gap of 2 cycles.
- `enable` dropping during CALC: the operation still completes and `done` still pulses, then the block returns to IDLE.
- `a`, `b` or `opcode` changing after acceptance: no effect.
- Reset asserted mid-CALC: the operation aborts immediately, no `done` is produced, and all outputs take their reset values.

## Configuration
- `ALU_DATAPATH_DIV_EN` defined:
  - opcode 3 performs the iterative DIV described above;
  - `div_by_zero` is live.
- `ALU_DATAPATH_DIV_EN` undefined:
  - no divider logic is built;
  - opcode 3 is treated as invalid (`result`=0, latency 1);
  - `div_by_zero` is tied to 0.

## Test plan
- Reset low during CALC of MUL 200×3 → all outputs 0 immediately, no `done`. After release, ADD 1,1 → `result`=2.
- ADD a=255,b=255 → `done` at E+1, `result`=0x01FE. SUB a=3,b=5 → `result`=0xFFFE.
- MUL a=255,b=255 → `done` exactly at E+9, `result`=0xFE01. `busy` is high for cycles E+1..E+9.
- DIV a=200,b=7 (macro defined) → `result`=0x041C, `div_by_zero`=0. DIV a=9,b=0 → `result`=0x09FF, `div_by_zero`=1.
- Macro undefined, opcode 3, a=9, b=3 → `done` at E+1, `result`=0, `div_by_zero`=0.
- `enable` held high for 5 cycles after `done` → exactly one `done` pulse. Then `enable` goes 0 for 1 cycle and 1 again with ADD 2,3 → new `done`, `result`=5.
